// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// Sequencing controller wrapped around a prescaled up-counter. A start in
// IDLE captures the period length, the prescale ratio and the reload mode.
// The counter then advances once per prescaled tick until it reaches its
// terminal count. At that point it either reloads or returns to IDLE.
// pause freezes counting. stop aborts without a done pulse.
// All outputs are registered.

module counter_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               auto_reload,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic [7:0]         wrap_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]         WRAP_MAX  = 8'hFF;

  state_t             state_reg,     state_next;
  logic [WIDTH-1:0]   count_reg,     count_next;
  logic [PRESC_W-1:0] presc_cnt_reg, presc_cnt_next;
  logic [WIDTH-1:0]   limit_reg,     limit_next;
  logic [PRESC_W-1:0] presc_reg,     presc_next;
  logic               reload_reg,    reload_next;
  logic               busy_reg,      busy_next;
  logic               done_reg,      done_next;
  logic [7:0]         wrap_reg,      wrap_next;

  // Terminal count. It is only consulted while busy, and limit_reg is
  // never zero there, so the subtraction cannot underflow in use.
  logic [WIDTH-1:0] limit_m1;
  assign limit_m1 = limit_reg - COUNT_ONE;

  // State and datapath registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      presc_cnt_reg <= '0;
      limit_reg     <= '0;
      presc_reg     <= '0;
      reload_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wrap_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      presc_cnt_reg <= presc_cnt_next;
      limit_reg     <= limit_next;
      presc_reg     <= presc_next;
      reload_reg    <= reload_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      wrap_reg      <= wrap_next;
    end
  end

  // Next-state logic. Control decisions come first. The shared advance
  // path below handles the prescaler, the tick and the terminal count.
  always_comb begin
    logic advance;
    advance        = 1'b0;
    state_next     = state_reg;
    count_next     = count_reg;
    presc_cnt_next = presc_cnt_reg;
    limit_next     = limit_reg;
    presc_next     = presc_reg;
    reload_next    = reload_reg;
    wrap_next      = wrap_reg;
    done_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // stop has no meaning here, so start alone decides.
        if (start) begin
          limit_next     = limit;
          presc_next     = prescale;
          reload_next    = auto_reload;
          count_next     = '0;
          presc_cnt_next = '0;
          wrap_next      = '0;
          if (limit != '0) begin
            state_next = ST_RUN;
          end else begin
            // An empty period completes immediately.
            done_next = 1'b1;
          end
        end
      end

      ST_RUN, ST_HOLD: begin
        if (stop) begin
          // Abort. count keeps its last value for inspection.
          state_next     = ST_IDLE;
          presc_cnt_next = '0;
        end else if (pause) begin
          // Frozen. The prescaler phase is kept for the resume.
          state_next = ST_HOLD;
        end else begin
          // Released from HOLD or still running. Either way this edge
          // counts, so a pause costs exactly the cycles it was held.
          state_next = ST_RUN;
          advance    = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (presc_cnt_reg == presc_reg) begin
        presc_cnt_next = '0;
        if (count_reg == limit_m1) begin
          count_next = '0;
          done_next  = 1'b1;
          if (wrap_reg != WRAP_MAX) begin
            wrap_next = wrap_reg + 8'd1;
          end
          if (!reload_reg) begin
            state_next = ST_IDLE;
          end
        end else begin
          count_next = count_reg + COUNT_ONE;
        end
      end else begin
        presc_cnt_next = presc_cnt_reg + PRESC_ONE;
      end
    end

    busy_next = (state_next != ST_IDLE);
  end

  assign count    = count_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign wrap_cnt = wrap_reg;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Testbench for counter_seq_ctrl. It runs a table of hand-computed
// vectors, then hand-written multi-cycle sequences, then a randomized run
// checked against an elapsed-time model of the counter.

module tb_counter_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic [7:0] limit;
  logic [3:0] prescale;
  logic       auto_reload;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic [7:0] wrap_cnt;

  int tests = 0;
  int fails = 0;

  counter_seq_ctrl #(.WIDTH(8), .PRESC_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .limit(limit), .prescale(prescale), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done), .wrap_cnt(wrap_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model. It tracks how many active, unpaused cycles have
  // elapsed since the start. count, done and wrap follow from division.
  int m_active, m_L, m_P, m_count, m_wrap;
  bit m_R, m_busy, m_done;

  task automatic model_step();
    int per;
    if (reset) begin
      m_busy = 0; m_done = 0; m_count = 0; m_wrap = 0; m_active = 0;
      m_L = 0; m_P = 0; m_R = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (start) begin
        m_L = int'(limit); m_P = int'(prescale); m_R = auto_reload;
        m_count = 0; m_wrap = 0; m_active = 0;
        if (m_L == 0) m_done = 1;
        else m_busy = 1;
      end
    end else begin
      m_done = 0;
      if (stop) begin
        m_busy = 0;
      end else if (!pause) begin
        m_active++;
        per = m_L * (m_P + 1);
        m_count = (m_active / (m_P + 1)) % m_L;
        if (m_active % per == 0) begin
          m_done = 1;
          if (m_wrap < 255) m_wrap++;
          if (!m_R) m_busy = 0;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit sp, input bit ps,
                       input int lim, input int pre, input bit ar);
    reset = r; start = st; stop = sp; pause = ps;
    limit = 8'(lim); prescale = 4'(pre); auto_reload = ar;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: the model sees the same sampled inputs as the DUT, and
  // outputs are checked 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       rst, st, sp, ps;
    logic [7:0] lim;
    logic [3:0] pre;
    logic       ar;
    logic [7:0] e_cnt;
    logic       e_busy, e_done;
    logic [7:0] e_wrap;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input bit r, input bit st, input bit sp, input bit ps,
                              input int lim, input int pre, input bit ar,
                              input int ec, input bit eb, input bit ed, input int ew);
    vec_t v;
    v.rst = r; v.st = st; v.sp = sp; v.ps = ps;
    v.lim = 8'(lim); v.pre = 4'(pre); v.ar = ar;
    v.e_cnt = 8'(ec); v.e_busy = eb; v.e_done = ed; v.e_wrap = 8'(ew);
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    idle_in();

    //             rst st sp ps lim pre ar  cnt busy done wrap
    vecs[0]  = mk(1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0,  3, 0, 0,   0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0,  0, 0, 0,   1, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0,  0, 0, 0,   2, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 1);
    vecs[5]  = mk(0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 1);
    vecs[6]  = mk(0, 1, 0, 0,  0, 0, 0,   0, 0, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 0, 10, 0, 0,   0, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0,  0, 0, 0,   1, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 0,  0, 0, 0,   2, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0,  0, 0, 0,   3, 1, 0, 0);
    vecs[12] = mk(0, 0, 1, 1,  0, 0, 0,   3, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0,  0, 0, 0,   3, 0, 0, 0);
    vecs[14] = mk(0, 1, 1, 0,  2, 0, 0,   0, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 0,  0, 0, 0,   1, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 1);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].ps,
            int'(vecs[i].lim), int'(vecs[i].pre), vecs[i].ar);
      cycle();
      chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
      chk($sformatf("vec%0d_wrap", i), int'(wrap_cnt), int'(vecs[i].e_wrap));
      $display("[TB] vec %0d: count=%0d busy=%0d done=%0d wrap=%0d",
               i, count, busy, done, wrap_cnt);
    end

    // Auto-reload, limit 4, prescale 2: tick every 3 cycles, done every 12.
    drive(0, 1, 0, 0, 4, 2, 1);
    cycle();
    idle_in();
    for (int k = 1; k <= 30; k++) begin
      cycle();
      chk($sformatf("reload_count_k%0d", k), int'(count), (k / 3) % 4);
      chk($sformatf("reload_done_k%0d", k), int'(done), (k % 12 == 0) ? 1 : 0);
      chk($sformatf("reload_busy_k%0d", k), int'(busy), 1);
    end
    chk("reload_wrap", int'(wrap_cnt), 2);
    $display("[TB] seq reload: wrap=%0d busy=%0d", wrap_cnt, busy);
    drive(0, 0, 1, 0, 0, 0, 0);
    cycle();
    chk("reload_stop_busy", int'(busy), 0);
    chk("reload_stop_done", int'(done), 0);
    idle_in();
    cycle();

    // One-shot limit 5 with a 4-cycle pause at count 2: done moves to edge 9.
    drive(0, 1, 0, 0, 5, 0, 0);
    cycle();
    idle_in();
    cycle();
    cycle();
    chk("pause_pre_count", int'(count), 2);
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("pause_hold_count%0d", k), int'(count), 2);
      chk($sformatf("pause_hold_busy%0d", k), int'(busy), 1);
      chk($sformatf("pause_hold_done%0d", k), int'(done), 0);
    end
    pause = 1'b0;
    e = 6;
    for (int k = 0; k < 20; k++) begin
      cycle();
      e++;
      if (done) break;
    end
    chk("pause_done_edge", e, 9);
    chk("pause_end_busy", int'(busy), 0);
    $display("[TB] seq pause: done at edge %0d", e);
    cycle();

    // A start while busy must not change the period or the limit.
    drive(0, 1, 0, 0, 3, 1, 1);
    cycle();
    idle_in();
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) drive(0, 1, 0, 0, 7, 0, 0);
      else idle_in();
      cycle();
      chk($sformatf("busystart_count_k%0d", k), int'(count), (k / 2) % 3);
      chk($sformatf("busystart_done_k%0d", k), int'(done), (k % 6 == 0) ? 1 : 0);
    end
    chk("busystart_wrap", int'(wrap_cnt), 2);
    $display("[TB] seq busy-start: wrap=%0d", wrap_cnt);
    drive(0, 0, 1, 0, 0, 0, 0);
    cycle();
    idle_in();

    // Reset mid-run with count 7, wrap 3. Then a sub-cycle reset glitch.
    drive(0, 1, 0, 0, 10, 0, 1);
    cycle();
    idle_in();
    for (int k = 0; k < 37; k++) cycle();
    chk("midrst_pre_count", int'(count), 7);
    chk("midrst_pre_wrap", int'(wrap_cnt), 3);
    reset = 1'b1;
    cycle();
    chk("midrst_count", int'(count), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_wrap", int'(wrap_cnt), 0);
    $display("[TB] seq mid-run reset: count=%0d busy=%0d wrap=%0d", count, busy, wrap_cnt);
    drive(0, 1, 0, 0, 5, 0, 0);
    cycle();
    idle_in();
    cycle();
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    cycle();
    chk("glitch_count", int'(count), 2);
    chk("glitch_busy", int'(busy), 1);
    $display("[TB] seq reset glitch: count=%0d busy=%0d", count, busy);

    // Randomized run against the model.
    for (int k = 0; k < 3000; k++) begin
      int r;
      int lim;
      r = int'($urandom_range(0, 9));
      lim = (r == 0) ? 0 : (r == 1) ? 255 : int'($urandom_range(1, 6));
      drive(($urandom % 200) == 0, ($urandom % 6) == 0, ($urandom % 25) == 0,
            ($urandom % 5) == 0, lim, int'($urandom_range(0, 3)), $urandom % 2);
      cycle();
      chk($sformatf("rand%0d_count", k), int'(count), m_count);
      chk($sformatf("rand%0d_busy", k), int'(busy), int'(m_busy));
      chk($sformatf("rand%0d_done", k), int'(done), int'(m_done));
      chk($sformatf("rand%0d_wrap", k), int'(wrap_cnt), m_wrap);
    end
    $display("[TB] random phase: 3000 cycles compared");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
